// File: rtl/wts_envelope_scheduler.sv
// -----------------------------------------------------------------------------
// wts_envelope_scheduler
//
// Purpose:
//   Time-multiplexes one external envelope generator across 8 channels. Each
//   sweep_start requests one service pass over channels 0..7, one channel per
//   cycle. In a channel's service cycle the block presents that channel's
//   stored context (counter/state/level) and its pending key requests to the
//   generator. At the clock edge that ends the cycle it stores the generator's
//   next context back into the channel.
//
// Ports:
//   clk                 system clock, rising edge
//   nreset              asynchronous active-low reset
//   sweep_start         pulse, request one pass over channels 0..7
//   key_on_req          per-channel key-on request pulses (bit n = channel n)
//   key_release_req     per-channel key-release request pulses
//   key_off_req         per-channel key-off request pulses
//   eg_key_on/_release/_off   pending request flags of the channel in service
//   eg_counter_in/state_in/level_in   stored context of the channel in service
//   eg_counter_out/state_out/level_out  next context from the generator
//   eg_ch               channel index in service
//   level_valid         pulse, level/level_ch carry a written-back level
//   level               written-back envelope level (0..128)
//   level_ch            channel of level
//   channel_active      bit n set while channel n's stored state is non-zero
//   busy                high while a pass is in progress
//   overrun             pulse, a sweep_start was dropped
// -----------------------------------------------------------------------------
module wts_envelope_scheduler (
  input  logic        clk,
  input  logic        nreset,
  input  logic        sweep_start,
  input  logic [7:0]  key_on_req,
  input  logic [7:0]  key_release_req,
  input  logic [7:0]  key_off_req,
  output logic        eg_key_on,
  output logic        eg_key_release,
  output logic        eg_key_off,
  output logic [15:0] eg_counter_in,
  output logic [2:0]  eg_state_in,
  output logic [7:0]  eg_level_in,
  input  logic [15:0] eg_counter_out,
  input  logic [2:0]  eg_state_out,
  input  logic [7:0]  eg_level_out,
  output logic [2:0]  eg_ch,
  output logic        level_valid,
  output logic [7:0]  level,
  output logic [2:0]  level_ch,
  output logic [7:0]  channel_active,
  output logic        busy,
  output logic        overrun
);

  localparam int NUM_CH = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    SERVE = 1'b1
  } fsm_t;

  fsm_t        state_reg, state_next;
  logic [2:0]  ch_reg, ch_next;
  logic        sweep_pending_reg, sweep_pending_next;
  logic        overrun_reg, overrun_next;
  logic        serve;

  logic [7:0]  on_pend_reg, rel_pend_reg, off_pend_reg;
  logic [7:0]  service_mask;

  logic        level_valid_reg;
  logic [7:0]  level_reg;
  logic [2:0]  level_ch_reg;

  logic [15:0] counter_arr [NUM_CH];
  logic [2:0]  state_arr   [NUM_CH];
  logic [7:0]  level_arr   [NUM_CH];

  // ---------------------------------------------------------------------------
  // Pass sequencing
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next         = state_reg;
    ch_next            = ch_reg;
    sweep_pending_next = sweep_pending_reg;
    overrun_next       = 1'b0;
    serve              = 1'b0;

    case (state_reg)
      IDLE: begin
        if (sweep_start) begin
          state_next = SERVE;
          ch_next    = 3'd0;
        end
      end

      SERVE: begin
        serve = 1'b1;
        // Only one request can be queued behind the running pass.
        if (sweep_start) begin
          if (sweep_pending_reg) begin
            overrun_next = 1'b1;
          end else begin
            sweep_pending_next = 1'b1;
          end
        end

        if (ch_reg == 3'd7) begin
          ch_next = 3'd0;
          // A request queued earlier, or arriving now on the last channel,
          // starts the next pass directly with no idle gap and is consumed.
          if (sweep_pending_reg || sweep_start) begin
            state_next         = SERVE;
            sweep_pending_next = 1'b0;
          end else begin
            state_next = IDLE;
          end
        end else begin
          ch_next = ch_reg + 3'd1;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_reg         <= IDLE;
      ch_reg            <= 3'd0;
      sweep_pending_reg <= 1'b0;
      overrun_reg       <= 1'b0;
    end else begin
      state_reg         <= state_next;
      ch_reg            <= ch_next;
      sweep_pending_reg <= sweep_pending_next;
      overrun_reg       <= overrun_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Sticky request flags. The served channel's flags are cleared first and new
  // requests are OR-ed in afterwards, so a request landing in its own service
  // cycle survives until the next pass.
  // ---------------------------------------------------------------------------
  assign service_mask = serve ? (8'd1 << ch_reg) : 8'd0;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      on_pend_reg  <= 8'd0;
      rel_pend_reg <= 8'd0;
      off_pend_reg <= 8'd0;
    end else begin
      on_pend_reg  <= (on_pend_reg  & ~service_mask) | key_on_req;
      rel_pend_reg <= (rel_pend_reg & ~service_mask) | key_release_req;
      off_pend_reg <= (off_pend_reg & ~service_mask) | key_off_req;
    end
  end

  // Flags pass through unfiltered; the generator decides priority.
  assign eg_key_on      = serve & on_pend_reg[ch_reg];
  assign eg_key_release = serve & rel_pend_reg[ch_reg];
  assign eg_key_off     = serve & off_pend_reg[ch_reg];

  // ---------------------------------------------------------------------------
  // Per-channel context storage. Held in flops because the whole context set
  // must clear asynchronously on reset.
  // ---------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic        wr_en;
      logic [15:0] ctx_counter_reg;
      logic [2:0]  ctx_state_reg;
      logic [7:0]  ctx_level_reg;

      assign wr_en = serve && (ch_reg == 3'(gi));

      always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
          ctx_counter_reg <= 16'd0;
          ctx_state_reg   <= 3'd0;
          ctx_level_reg   <= 8'd0;
        end else if (wr_en) begin
          ctx_counter_reg <= eg_counter_out;
          ctx_state_reg   <= eg_state_out;
          ctx_level_reg   <= eg_level_out;
        end
      end

      assign counter_arr[gi]    = ctx_counter_reg;
      assign state_arr[gi]      = ctx_state_reg;
      assign level_arr[gi]      = ctx_level_reg;
      assign channel_active[gi] = (ctx_state_reg != 3'd0);
    end
  endgenerate

  assign eg_counter_in = counter_arr[ch_reg];
  assign eg_state_in   = state_arr[ch_reg];
  assign eg_level_in   = level_arr[ch_reg];

  // ---------------------------------------------------------------------------
  // Write-back report, one cycle after each service cycle
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      level_valid_reg <= 1'b0;
      level_reg       <= 8'd0;
      level_ch_reg    <= 3'd0;
    end else begin
      level_valid_reg <= serve;
      if (serve) begin
        level_reg    <= eg_level_out;
        level_ch_reg <= ch_reg;
      end
    end
  end

  assign level_valid = level_valid_reg;
  assign level       = level_reg;
  assign level_ch    = level_ch_reg;
  assign eg_ch       = ch_reg;
  assign busy        = (state_reg == SERVE);
  assign overrun     = overrun_reg;

endmodule

// File: tb/tb_wts_envelope_scheduler.sv
// -----------------------------------------------------------------------------
// tb_wts_envelope_scheduler
//
// Bench for wts_envelope_scheduler. A small stand-in envelope generator answers
// the scheduler combinationally:
//   key_off -> idle (state 0, level 0)
//   key_on  -> state 1, level 128 (instant attack)
//   release -> state 2, level 64
//   no key  -> hold; the counter advances while the state is non-zero.
// Each scenario task pushes the levels it expects into a queue. A monitor pops
// one entry per level_valid pulse and compares it.
// -----------------------------------------------------------------------------
module tb_wts_envelope_scheduler;

  logic        clk;
  logic        nreset;
  logic        sweep_start;
  logic [7:0]  key_on_req, key_release_req, key_off_req;
  logic        eg_key_on, eg_key_release, eg_key_off;
  logic [15:0] eg_counter_in, eg_counter_out;
  logic [2:0]  eg_state_in, eg_state_out;
  logic [7:0]  eg_level_in, eg_level_out;
  logic [2:0]  eg_ch;
  logic        level_valid;
  logic [7:0]  level;
  logic [2:0]  level_ch;
  logic [7:0]  channel_active;
  logic        busy;
  logic        overrun;

  int n_compared   = 0;
  int n_mismatched = 0;

  typedef struct {
    logic [2:0] ch;
    logic [7:0] lvl;
  } exp_t;

  exp_t exp_q[$];

  wts_envelope_scheduler dut (
    .clk            (clk),
    .nreset         (nreset),
    .sweep_start    (sweep_start),
    .key_on_req     (key_on_req),
    .key_release_req(key_release_req),
    .key_off_req    (key_off_req),
    .eg_key_on      (eg_key_on),
    .eg_key_release (eg_key_release),
    .eg_key_off     (eg_key_off),
    .eg_counter_in  (eg_counter_in),
    .eg_state_in    (eg_state_in),
    .eg_level_in    (eg_level_in),
    .eg_counter_out (eg_counter_out),
    .eg_state_out   (eg_state_out),
    .eg_level_out   (eg_level_out),
    .eg_ch          (eg_ch),
    .level_valid    (level_valid),
    .level          (level),
    .level_ch       (level_ch),
    .channel_active (channel_active),
    .busy           (busy),
    .overrun        (overrun)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Stand-in envelope generator
  always_comb begin
    eg_counter_out = eg_counter_in;
    eg_state_out   = eg_state_in;
    eg_level_out   = eg_level_in;
    if (eg_key_off) begin
      eg_counter_out = 16'd0;
      eg_state_out   = 3'd0;
      eg_level_out   = 8'd0;
    end else if (eg_key_on) begin
      eg_counter_out = 16'd0;
      eg_state_out   = 3'd1;
      eg_level_out   = 8'd128;
    end else if (eg_key_release) begin
      eg_counter_out = 16'd0;
      eg_state_out   = 3'd2;
      eg_level_out   = 8'd64;
    end else if (eg_state_in != 3'd0) begin
      eg_counter_out = eg_counter_in + 16'd1;
    end
  end

  // Scoreboard: one expected entry per level_valid pulse
  always @(negedge clk) begin
    if (level_valid === 1'b1) begin
      n_compared++;
      if (exp_q.size() == 0) begin
        n_mismatched++;
        $display("FAIL level_unexpected: got ch=%0d level=%0d required no write-back", level_ch, level);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (level_ch !== e.ch || level !== e.lvl) begin
          n_mismatched++;
          $display("FAIL level_wb: got ch=%0d level=%0d required ch=%0d level=%0d",
                   level_ch, level, e.ch, e.lvl);
        end else begin
          $display("level write-back ch=%0d level=%0d ok", level_ch, level);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Queue expected write-back levels for channels 0..n-1 (byte i = channel i)
  task automatic push_levels(input logic [63:0] lv, input int n);
    for (int i = 0; i < n; i++) begin
      exp_t e;
      e.ch  = 3'(i);
      e.lvl = lv[8*i +: 8];
      exp_q.push_back(e);
    end
  endtask

  task automatic test_reset();
    logic [47:0] got;
    nreset = 1'b0; sweep_start = 1'b0;
    key_on_req = 8'd0; key_release_req = 8'd0; key_off_req = 8'd0;
    #1;
    got = {busy, overrun, level_valid, eg_key_on, eg_key_release, eg_key_off,
           eg_ch, channel_active, level, level_ch, eg_counter_in, eg_state_in, eg_level_in[0]};
    n_compared++;
    if (got !== 48'd0) begin
      n_mismatched++;
      $display("FAIL reset_outputs: got %h required 0", got);
    end
    step(); step();
    nreset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      n_compared++;
      if ({busy, level_valid, eg_level_in} !== 10'd0) begin
        n_mismatched++;
        $display("FAIL reset_idle_%0d: got busy=%b lv=%b eg_level_in=%0d required 0 0 0",
                 k, busy, level_valid, eg_level_in);
      end
    end
  endtask

  // Pass over freshly reset channels: timing of busy, eg_ch and level_valid
  task automatic test_idle_pass();
    logic [7:0] got, exp;
    sweep_start = 1'b1;
    push_levels(64'd0, 8);
    step();
    sweep_start = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      got = {busy, eg_ch, level_valid, eg_key_on, eg_key_release, eg_key_off};
      exp = {(k <= 8), (k <= 8) ? 3'(k - 1) : 3'd0, (k >= 2 && k <= 9), 3'b000};
      n_compared++;
      if (got !== exp) begin
        n_mismatched++;
        $display("FAIL idle_pass_T+%0d: got {busy,ch,lv,keys}=%b required %b", k, got, exp);
      end
      step();
    end
    n_compared++;
    if (channel_active !== 8'h00) begin
      n_mismatched++;
      $display("FAIL idle_pass_active: got %h required 00", channel_active);
    end
  endtask

  task automatic test_key_on();
    logic [3:0] got, exp;
    key_on_req = 8'h04;
    step();
    key_on_req = 8'h00;
    sweep_start = 1'b1;
    push_levels(64'h0000_0000_0080_0000, 8);
    step();
    sweep_start = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      got = {eg_ch, eg_key_on};
      exp = {3'(k - 1), (k - 1 == 2)};
      n_compared++;
      if (got !== exp || eg_key_off !== 1'b0 || eg_key_release !== 1'b0) begin
        n_mismatched++;
        $display("FAIL key_on_ch%0d: got ch=%0d on=%b rel=%b off=%b required ch=%0d on=%b rel=0 off=0",
                 k - 1, eg_ch, eg_key_on, eg_key_release, eg_key_off, exp[3:1], exp[0]);
      end
      step();
    end
    n_compared++;
    if (channel_active !== 8'h04) begin
      n_mismatched++;
      $display("FAIL key_on_active: got %h required 04", channel_active);
    end
  endtask

  // key_on_req[3] raised exactly in channel 3's service cycle
  task automatic test_same_cycle_request();
    sweep_start = 1'b1;
    push_levels(64'h0000_0000_0080_0000, 8);
    step();
    sweep_start = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      n_compared++;
      if (eg_key_on !== 1'b0) begin
        n_mismatched++;
        $display("FAIL same_cycle_pass1_ch%0d: got eg_key_on=%b required 0", k - 1, eg_key_on);
      end
      if (k == 3) begin
        n_compared++;
        if (eg_counter_in !== 16'd0 || eg_state_in !== 3'd1 || eg_level_in !== 8'd128) begin
          n_mismatched++;
          $display("FAIL ctx_ch2_pass1: got cnt=%0d st=%0d lvl=%0d required 0 1 128",
                   eg_counter_in, eg_state_in, eg_level_in);
        end
      end
      key_on_req = (k == 4) ? 8'h08 : 8'h00;
      step();
    end
    key_on_req = 8'h00;
    sweep_start = 1'b1;
    push_levels(64'h0000_0000_8080_0000, 8);
    step();
    sweep_start = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      n_compared++;
      if (eg_key_on !== (k == 4)) begin
        n_mismatched++;
        $display("FAIL same_cycle_pass2_ch%0d: got eg_key_on=%b required %b", k - 1, eg_key_on, (k == 4));
      end
      if (k == 3) begin
        n_compared++;
        if (eg_counter_in !== 16'd1) begin
          n_mismatched++;
          $display("FAIL ctx_ch2_counter: got %0d required 1", eg_counter_in);
        end
      end
      step();
    end
    n_compared++;
    if (channel_active !== 8'h0C) begin
      n_mismatched++;
      $display("FAIL same_cycle_active: got %h required 0c", channel_active);
    end
  endtask

  // sweep_start at T, T+3, T+5: second pass back-to-back, third dropped
  task automatic test_back_to_back();
    logic [4:0] got, exp;
    sweep_start = 1'b1;
    push_levels(64'h0000_0000_8080_0000, 8);
    push_levels(64'h0000_0000_8080_0000, 8);
    step();
    for (int k = 1; k <= 17; k++) begin
      got = {busy, eg_ch, overrun};
      exp = {(k <= 16), (k <= 16) ? 3'((k - 1) % 8) : 3'd0, (k == 6)};
      n_compared++;
      if (got !== exp) begin
        n_mismatched++;
        $display("FAIL back_to_back_T+%0d: got {busy,ch,overrun}=%b required %b", k, got, exp);
      end
      sweep_start = (k == 3 || k == 5);
      step();
    end
    sweep_start = 1'b0;
  endtask

  // off on ch2, release on ch3, simultaneous on+off on ch6
  task automatic test_key_off();
    logic [2:0] got, exp;
    key_off_req = 8'h44; key_release_req = 8'h08; key_on_req = 8'h40;
    step();
    key_off_req = 8'h00; key_release_req = 8'h00; key_on_req = 8'h00;
    sweep_start = 1'b1;
    push_levels(64'h0000_0000_4000_0000, 8);
    step();
    sweep_start = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      got = {eg_key_on, eg_key_release, eg_key_off};
      exp = {(k - 1 == 6), (k - 1 == 3), (k - 1 == 2 || k - 1 == 6)};
      n_compared++;
      if (got !== exp) begin
        n_mismatched++;
        $display("FAIL key_flags_ch%0d: got {on,rel,off}=%b required %b", k - 1, got, exp);
      end
      step();
    end
    n_compared++;
    if (channel_active !== 8'h08) begin
      n_mismatched++;
      $display("FAIL key_off_active: got %h required 08", channel_active);
    end
  endtask

  // sweep_start on the last service cycle chains a second pass with no overrun
  task automatic test_last_cycle_sweep();
    logic [4:0] got, exp;
    sweep_start = 1'b1;
    push_levels(64'h0000_0000_4000_0000, 8);
    push_levels(64'h0000_0000_4000_0000, 8);
    step();
    for (int k = 1; k <= 17; k++) begin
      got = {busy, eg_ch, overrun};
      exp = {(k <= 16), (k <= 16) ? 3'((k - 1) % 8) : 3'd0, 1'b0};
      n_compared++;
      if (got !== exp) begin
        n_mismatched++;
        $display("FAIL last_cycle_T+%0d: got {busy,ch,overrun}=%b required %b", k, got, exp);
      end
      if (k == 3) begin
        n_compared++;
        if (eg_state_in !== 3'd0 || eg_level_in !== 8'd0) begin
          n_mismatched++;
          $display("FAIL ctx_ch2_after_off: got st=%0d lvl=%0d required 0 0", eg_state_in, eg_level_in);
        end
      end
      sweep_start = (k == 8);
      step();
    end
    sweep_start = 1'b0;
  endtask

  // Reset while channel 4 is in service, with a key-on for ch5 still pending
  task automatic test_reset_mid_pass();
    sweep_start = 1'b1;
    push_levels(64'h0000_0000_4000_0000, 4);
    step();
    sweep_start = 1'b0;
    key_on_req = 8'h20;
    step();
    key_on_req = 8'h00;
    step(); step(); step();
    n_compared++;
    if (busy !== 1'b1 || eg_ch !== 3'd4) begin
      n_mismatched++;
      $display("FAIL mid_pass_position: got busy=%b ch=%0d required 1 4", busy, eg_ch);
    end
    @(negedge clk);
    #1;
    nreset = 1'b0;
    #1;
    n_compared++;
    if ({busy, level_valid, overrun, eg_ch, channel_active, eg_level_in, eg_state_in} !== 25'd0) begin
      n_mismatched++;
      $display("FAIL mid_pass_reset: got busy=%b lv=%b ovr=%b ch=%0d active=%h lvl_in=%0d st_in=%0d required all 0",
               busy, level_valid, overrun, eg_ch, channel_active, eg_level_in, eg_state_in);
    end
    step(); step();
    nreset = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      n_compared++;
      if (busy !== 1'b0 || level_valid !== 1'b0) begin
        n_mismatched++;
        $display("FAIL post_reset_idle_%0d: got busy=%b lv=%b required 0 0", k, busy, level_valid);
      end
    end
    sweep_start = 1'b1;
    push_levels(64'd0, 8);
    step();
    sweep_start = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      n_compared++;
      if (eg_key_on !== 1'b0 || eg_state_in !== 3'd0 || eg_level_in !== 8'd0 || eg_counter_in !== 16'd0) begin
        n_mismatched++;
        $display("FAIL post_reset_ch%0d: got on=%b st=%0d lvl=%0d cnt=%0d required 0 0 0 0",
                 k - 1, eg_key_on, eg_state_in, eg_level_in, eg_counter_in);
      end
      step();
    end
    n_compared++;
    if (channel_active !== 8'h00) begin
      n_mismatched++;
      $display("FAIL post_reset_active: got %h required 00", channel_active);
    end
  endtask

  initial begin
    test_reset();
    test_idle_pass();
    test_key_on();
    test_same_cycle_request();
    test_back_to_back();
    test_key_off();
    test_last_cycle_sweep();
    test_reset_mid_pass();
    step(); step(); step();
    n_compared++;
    if (exp_q.size() != 0) begin
      n_mismatched++;
      $display("FAIL scoreboard_drain: got %0d entries left required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
